// File: rtl/key_schedule_iter.sv
// key_schedule_iter: iterative AES-128/192/256 key expansion, one schedule word per clock,
// streamed out as 128-bit round keys on a valid/ready port.
module key_schedule_iter #(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              key_size,
  input  logic [MAX_KEY_BITS-1:0] key_in,
  output logic                    busy,
  output logic                    rk_valid,
  input  logic                    rk_ready,
  output logic [127:0]            rk_data,
  output logic [3:0]              rk_idx,
  output logic                    done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;
  logic [1:0] mode, mode_in;
  logic [255:0] key_q, key_pad, win;
  logic [5:0] i, last;
  logic [2:0] m;
  logic [7:0] rcon;
  logic [3:0] nk;
  logic [31:0] rot_t, sub_t, tn, tap, w;
  logic adv, accept, rk_word;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = b[k] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // S-box as GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] p, r;
    p = b;
    r = 8'h01;
    for (int k = 0; k < 7; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [31:0] subword(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction
  assign key_pad = 256'(key_in) << (256 - MAX_KEY_BITS);
  assign busy = state != IDLE;
  always_comb begin
    mode_in = (key_size == 2'd1 && MAX_KEY_BITS >= 192) ? 2'd1 :
              (key_size == 2'd2 && MAX_KEY_BITS >= 256) ? 2'd2 : 2'd0;
    nk = mode == 2'd2 ? 4'd8 : mode == 2'd1 ? 4'd6 : 4'd4;
    last = mode == 2'd2 ? 6'd59 : mode == 2'd1 ? 6'd51 : 6'd43;
    // win holds w[i-1] in its low word, w[i-8] in its high word
    tap = mode == 2'd2 ? win[255:224] : mode == 2'd1 ? win[191:160] : win[127:96];
    accept = rk_valid && rk_ready;
    rk_word = i[1:0] == 2'd3;
    adv = state == RUN && (!rk_word || !rk_valid || rk_ready);
    rot_t = {win[23:0], win[31:24]};
    sub_t = subword(m == 3'd0 ? rot_t : win[31:0]);
    tn = m == 3'd0 ? sub_t ^ {rcon, 24'h0} : (mode == 2'd2 && m == 3'd4) ? sub_t : win[31:0];
    w = i < 6'(nk) ? key_q[255:224] : tap ^ tn;
    state_nxt = (state == IDLE && start) ? RUN :
                (state == RUN && adv && i == last) ? DRAIN :
                (state == DRAIN && accept) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= '0;
      key_q <= '0;
      win <= '0;
      i <= '0;
      m <= '0;
      rcon <= '0;
      rk_valid <= 1'b0;
      rk_data <= '0;
      rk_idx <= '0;
      done <= 1'b0;
    end else begin
      done <= state == DRAIN && accept;
      if (state == IDLE && start) begin
        mode <= mode_in;
        key_q <= key_pad;
        i <= '0;
        m <= '0;
        rcon <= 8'h01;
      end else if (adv) begin
        key_q <= {key_q[223:0], 32'h0};
        win <= {win[223:0], w};
        i <= i + 6'd1;
        m <= ({1'b0, m} == nk - 4'd1) ? 3'd0 : m + 3'd1;
        if (m == 3'd0 && i != 6'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        if (rk_word) begin
          rk_data <= {win[95:0], w};
          rk_idx <= i[5:2];
          rk_valid <= 1'b1;
        end else if (accept) rk_valid <= 1'b0;
      end else if (accept) rk_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_key_schedule_iter.sv
// tb_key_schedule_iter: directed FIPS-197 key-expansion vectors, timing, backpressure,
// reset and ignored-start scenarios for key_schedule_iter.
module tb_key_schedule_iter;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, rk_ready = 1'b0;
  logic [1:0] key_size = '0;
  logic [255:0] key_in = '0;
  logic busy, rk_valid, done;
  logic [127:0] rk_data;
  logic [3:0] rk_idx;
  int vec = 0, miss = 0;
  logic [127:0] k128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] rk1_128 = 128'ha0fafe1788542cb123a339392a6c7605;
  logic [127:0] rk10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  logic [191:0] k192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  logic [127:0] rk12_192 = 128'he98ba06f448c773c8ecc720401002202;
  logic [255:0] k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  logic [127:0] rk14_256 = 128'hfe4890d1e6188d0b046df344706c631e;
  logic [127:0] keys [16];
  int idxs [16];
  int cyc [16];
  int n, done_cyc, unstable;
  bit timeout;

  key_schedule_iter #(.MAX_KEY_BITS(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_size(key_size), .key_in(key_in),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
    .rk_idx(rk_idx), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic start_run(input logic [1:0] ks, input logic [255:0] k);
    @(negedge clk);
    key_size = ks;
    key_in = k;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // cycle c counts from 1 = first cycle after the start sampling edge
  task automatic collect(input int duty, input int stop_idx, input int repulse);
    logic [127:0] pd;
    logic [3:0] pi;
    bit stalled;
    n = 0; done_cyc = -1; unstable = 0; timeout = 1'b1; stalled = 1'b0; pd = '0; pi = '0;
    for (int c = 1; c < 3000; c++) begin
      @(negedge clk);
      start = (c == repulse);
      if (c == repulse) begin
        key_in = {k192, 64'h0123456789abcdef};
        key_size = 2'd1;
      end
      if (done) begin
        done_cyc = c;
        timeout = 1'b0;
        break;
      end
      if (stalled && (rk_data !== pd || rk_idx !== pi || rk_valid !== 1'b1)) unstable++;
      rk_ready = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
      stalled = rk_valid && !rk_ready;
      pd = rk_data;
      pi = rk_idx;
      if (rk_valid && rk_ready && n < 16) begin
        keys[n] = rk_data;
        idxs[n] = int'(rk_idx);
        cyc[n] = c;
        n++;
        if (int'(rk_idx) == stop_idx) begin
          timeout = 1'b0;
          @(posedge clk);
          #1 rk_ready = 1'b0;
          return;
        end
      end
    end
    start = 1'b0;
    rk_ready = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b1;
    #12;
    vec++; if ({busy, rk_valid, done, rk_idx} !== 7'd0 || rk_data !== '0) begin
      miss++; $display("FAIL reset_outputs got busy=%b v=%b done=%b idx=%h data=%h want all zero", busy, rk_valid, done, rk_idx, rk_data);
    end
    @(posedge clk);
    @(negedge clk);
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL reset_beats_start got busy=%b want 0", busy); end
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL idle_after_reset got busy=%b want 0", busy); end
  endtask

  task automatic test_aes128();
    logic [31:0] a, b, cw;
    start_run(2'd0, {k128, 128'h0});
    collect(100, 99, 0);
    vec++; if (timeout) begin miss++; $display("FAIL a128_timeout got no done want done"); end
    vec++; if (busy !== 1'b0 || rk_valid !== 1'b0) begin miss++; $display("FAIL a128_idle_at_done got busy=%b v=%b want 0 0", busy, rk_valid); end
    vec++; if (n !== 11) begin miss++; $display("FAIL a128_count got %0d want 11", n); end
    for (int k = 0; k < 11; k++) begin
      vec++; if (idxs[k] !== k) begin miss++; $display("FAIL a128_idx%0d got %0d want %0d", k, idxs[k], k); end
    end
    vec++; if (keys[0] !== k128) begin miss++; $display("FAIL a128_rk0 got %h want %h", keys[0], k128); end
    vec++; if (keys[1] !== rk1_128) begin miss++; $display("FAIL a128_rk1 got %h want %h", keys[1], rk1_128); end
    vec++; if (keys[10] !== rk10_128) begin miss++; $display("FAIL a128_rk10 got %h want %h", keys[10], rk10_128); end
    vec++; if (cyc[0] !== 5) begin miss++; $display("FAIL a128_rk0_cycle got %0d want 5", cyc[0]); end
    vec++; if (cyc[10] !== 45) begin miss++; $display("FAIL a128_rk10_cycle got %0d want 45", cyc[10]); end
    vec++; if (done_cyc !== 46) begin miss++; $display("FAIL a128_done_cycle got %0d want 46", done_cyc); end
    for (int r = 1; r < 11; r++)
      for (int j = 1; j < 4; j++) begin
        a = keys[r][127-32*j -: 32];
        b = keys[r-1][127-32*j -: 32];
        cw = keys[r][159-32*j -: 32];
        vec++; if (a !== (b ^ cw)) begin miss++; $display("FAIL a128_xor_r%0d_w%0d got %h want %h", r, j, a, b ^ cw); end
      end
    @(negedge clk);
    vec++; if (done !== 1'b0) begin miss++; $display("FAIL a128_done_pulse got %b want 0", done); end
  endtask

  task automatic test_aes192();
    start_run(2'd1, {k192, 64'h0});
    collect(100, 99, 0);
    vec++; if (timeout || n !== 13) begin miss++; $display("FAIL a192_count got %0d want 13", n); end
    vec++; if (keys[0] !== k192[191:64]) begin miss++; $display("FAIL a192_rk0 got %h want %h", keys[0], k192[191:64]); end
    vec++; if (keys[1][127:64] !== k192[63:0]) begin miss++; $display("FAIL a192_w4w5 got %h want %h", keys[1][127:64], k192[63:0]); end
    vec++; if (keys[1][63:32] !== 32'hfe0c91f7) begin miss++; $display("FAIL a192_w6 got %h want fe0c91f7", keys[1][63:32]); end
    vec++; if (idxs[12] !== 12 || keys[12] !== rk12_192) begin miss++; $display("FAIL a192_rk12 got idx=%0d %h want 12 %h", idxs[12], keys[12], rk12_192); end
    vec++; if (cyc[12] !== 53) begin miss++; $display("FAIL a192_rk12_cycle got %0d want 53", cyc[12]); end
  endtask

  task automatic test_aes256();
    start_run(2'd2, k256);
    collect(100, 99, 0);
    vec++; if (timeout || n !== 15) begin miss++; $display("FAIL a256_count got %0d want 15", n); end
    vec++; if (keys[0] !== k256[255:128] || keys[1] !== k256[127:0]) begin miss++; $display("FAIL a256_rk0_rk1 got %h %h want %h", keys[0], keys[1], k256); end
    vec++; if (idxs[14] !== 14 || keys[14] !== rk14_256) begin miss++; $display("FAIL a256_rk14 got idx=%0d %h want 14 %h", idxs[14], keys[14], rk14_256); end
    vec++; if (cyc[14] !== 61) begin miss++; $display("FAIL a256_rk14_cycle got %0d want 61", cyc[14]); end
    vec++; if (done_cyc !== 62) begin miss++; $display("FAIL a256_done_cycle got %0d want 62", done_cyc); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, cw;
    start_run(2'd0, {k128, 128'h0});
    collect(30, 99, 0);
    vec++; if (timeout || n !== 11) begin miss++; $display("FAIL bp_count got %0d want 11", n); end
    for (int k = 0; k < 11; k++) begin
      vec++; if (idxs[k] !== k) begin miss++; $display("FAIL bp_idx%0d got %0d want %0d", k, idxs[k], k); end
    end
    vec++; if (keys[0] !== k128) begin miss++; $display("FAIL bp_rk0 got %h want %h", keys[0], k128); end
    vec++; if (keys[1] !== rk1_128) begin miss++; $display("FAIL bp_rk1 got %h want %h", keys[1], rk1_128); end
    vec++; if (keys[10] !== rk10_128) begin miss++; $display("FAIL bp_rk10 got %h want %h", keys[10], rk10_128); end
    vec++; if (unstable !== 0) begin miss++; $display("FAIL bp_stable got %0d changes want 0", unstable); end
    for (int r = 1; r < 11; r++)
      for (int j = 1; j < 4; j++) begin
        a = keys[r][127-32*j -: 32];
        b = keys[r-1][127-32*j -: 32];
        cw = keys[r][159-32*j -: 32];
        vec++; if (a !== (b ^ cw)) begin miss++; $display("FAIL bp_xor_r%0d_w%0d got %h want %h", r, j, a, b ^ cw); end
      end
  endtask

  task automatic test_reset_midrun();
    start_run(2'd2, k256);
    collect(100, 5, 0);
    vec++; if (timeout || idxs[5] !== 5) begin miss++; $display("FAIL mid_reach_rk5 got n=%0d want rk5 accepted", n); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vec++; if ({busy, rk_valid, done, rk_idx} !== 7'd0 || rk_data !== '0) begin
      miss++; $display("FAIL mid_reset_async got busy=%b v=%b idx=%h data=%h want all zero", busy, rk_valid, rk_idx, rk_data);
    end
    @(posedge clk);
    @(negedge clk);
    vec++; if (busy !== 1'b0 || rk_valid !== 1'b0) begin miss++; $display("FAIL mid_reset_hold got busy=%b v=%b want 0 0", busy, rk_valid); end
    rst_n = 1'b1;
    start_run(2'd0, {k128, 128'h0});
    collect(100, 99, 0);
    vec++; if (timeout || n !== 11) begin miss++; $display("FAIL mid_rerun_count got %0d want 11", n); end
    vec++; if (keys[1] !== rk1_128 || keys[10] !== rk10_128) begin miss++; $display("FAIL mid_rerun_keys got %h %h want %h %h", keys[1], keys[10], rk1_128, rk10_128); end
    vec++; if (cyc[10] !== 45 || done_cyc !== 46) begin miss++; $display("FAIL mid_rerun_timing got %0d/%0d want 45/46", cyc[10], done_cyc); end
  endtask

  task automatic test_start_busy();
    start_run(2'd0, {k128, 128'h0});
    collect(100, 99, 12);
    vec++; if (timeout || n !== 11) begin miss++; $display("FAIL busy_start_count got %0d want 11", n); end
    vec++; if (keys[1] !== rk1_128 || keys[10] !== rk10_128) begin miss++; $display("FAIL busy_start_keys got %h %h want %h %h", keys[1], keys[10], rk1_128, rk10_128); end
    vec++; if (done_cyc !== 46) begin miss++; $display("FAIL busy_start_done got %0d want 46", done_cyc); end
    start_run(2'd3, {k128, 128'h0});
    collect(100, 99, 0);
    vec++; if (timeout || n !== 11) begin miss++; $display("FAIL code11_count got %0d want 11", n); end
    vec++; if (keys[0] !== k128 || keys[10] !== rk10_128) begin miss++; $display("FAIL code11_keys got %h %h want %h %h", keys[0], keys[10], k128, rk10_128); end
    vec++; if (cyc[10] !== 45) begin miss++; $display("FAIL code11_cycle got %0d want 45", cyc[10]); end
  endtask

  initial begin
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_backpressure();
    test_reset_midrun();
    test_start_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
